guardian_alert_collector: RTL and testbench

- Downstream consumer of N guardian_module instances.
- Captures each guardian's alert (block_id, anomaly_score) and filters out alerts below a score threshold.
- Coalesces repeat alerts from the same guardian while one is still pending.
- Round-robin arbitrates pending alerts into a FIFO, drained through a valid/ready port by the healing controller.

---
 rtl/guardian_alert_collector.sv | 177 +++++++++++++++++
 tb/tb_guardian_alert_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/guardian_alert_collector.sv
// guardian_alert_collector: gathers alerts from N guardian modules, drops
// low-score alerts, merges repeats from a guardian whose previous alert is
// still waiting, and queues the survivors round-robin into a show-ahead FIFO
// that the healing controller drains over a valid/ready port.

module guardian_alert_collector #(
   parameter int          N_GUARDIANS  = 4,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [15:0] SCORE_THRESH = 16'd64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [N_GUARDIANS-1:0]        alert_valid_in,
   input  logic [16*N_GUARDIANS-1:0]     anomaly_score_in,
   input  logic [16*N_GUARDIANS-1:0]     block_id_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [15:0]                   out_block_id,
   output logic [15:0]                   out_score,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [N_GUARDIANS-1:0]        pending_mask,
   output logic [15:0]                   coalesce_count
);

   localparam int IDX_W = (N_GUARDIANS > 1) ? $clog2(N_GUARDIANS) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [15:0]            score_in [N_GUARDIANS];
   logic [15:0]            id_in    [N_GUARDIANS];
   logic [N_GUARDIANS-1:0] accept;
   logic [N_GUARDIANS-1:0] granted;
   logic [N_GUARDIANS-1:0] coalesce_hit;

   logic [N_GUARDIANS-1:0] pending;
   logic [15:0]            lat_score [N_GUARDIANS];
   logic [15:0]            lat_id    [N_GUARDIANS];

   // rr_ptr holds the index the next search starts at, i.e. last_grant+1.
   // Resetting it to 0 is the same as last_grant = N_GUARDIANS-1.
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       rr_next;
   logic [IDX_W-1:0]       grant_idx;
   logic                   grant_valid;

   logic [31:0]            mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [31:0]            head;
   logic                   push;
   logic                   pop;
   logic                   can_push;
   logic [16:0]            coalesce_sum;
   logic [15:0]            coalesce_next;

   // Unpack the flattened guardian buses and qualify each alert against the threshold.
   always_comb begin
      for (int i = 0; i < N_GUARDIANS; i++) begin
         score_in[i] = anomaly_score_in[16*i +: 16];
         id_in[i]    = block_id_in[16*i +: 16];
         accept[i]   = enable & alert_valid_in[i] & (score_in[i] >= SCORE_THRESH);
      end
   end

   assign pop      = out_valid & out_ready;
   assign can_push = (fifo_level != LVL_W'(FIFO_DEPTH)) | pop;

   // Round-robin search for the first pending guardian starting at rr_ptr.
   always_comb begin
      int               cand;
      int               nxt;
      logic [IDX_W-1:0] cand_idx;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < N_GUARDIANS; k++) begin
         cand     = (int'(rr_ptr) + k) % N_GUARDIANS;
         cand_idx = IDX_W'(cand);
         if (!grant_valid && pending[cand_idx] && can_push) begin
            grant_valid = 1'b1;
            grant_idx   = cand_idx;
         end
      end
      nxt     = (int'(grant_idx) + 1) % N_GUARDIANS;
      rr_next = IDX_W'(nxt);
   end

   assign push = grant_valid;

   // Decode the grant per guardian and find repeats that merge into a pending alert.
   always_comb begin
      int n_coal;
      n_coal = 0;
      for (int i = 0; i < N_GUARDIANS; i++) begin
         granted[i]      = grant_valid && (grant_idx == IDX_W'(i));
         coalesce_hit[i] = accept[i] & pending[i] & ~granted[i];
         if (coalesce_hit[i]) begin
            n_coal = n_coal + 1;
         end
      end
      coalesce_sum  = {1'b0, coalesce_count} + 17'(n_coal);
      coalesce_next = coalesce_sum[16] ? 16'hFFFF : coalesce_sum[15:0];
   end

   // Per-guardian pending flag and latched alert; a re-alert on the grant cycle starts a fresh entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         for (int i = 0; i < N_GUARDIANS; i++) begin
            lat_score[i] <= '0;
            lat_id[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < N_GUARDIANS; i++) begin
            if (accept[i]) begin
               pending[i] <= 1'b1;
               lat_id[i]  <= id_in[i];
               if (!pending[i] || granted[i] || (score_in[i] > lat_score[i])) begin
                  lat_score[i] <= score_in[i];
               end
            end else if (granted[i]) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   // Arbitration pointer and saturating coalesce counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr         <= '0;
         coalesce_count <= '0;
      end else begin
         if (grant_valid) begin
            rr_ptr <= rr_next;
         end
         coalesce_count <= coalesce_next;
      end
   end

   // FIFO storage; contents are only visible through out_* while the level is nonzero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {lat_id[grant_idx], lat_score[grant_idx]};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   assign head         = mem[rd_ptr];
   assign out_valid    = (fifo_level != '0);
   assign out_block_id = out_valid ? head[31:16] : 16'd0;
   assign out_score    = out_valid ? head[15:0]  : 16'd0;
   assign pending_mask = pending;

endmodule

// File: tb/tb_guardian_alert_collector.sv
// tb_guardian_alert_collector: drives alert patterns into the collector and
// compares every entry leaving the FIFO against an ordered queue of expected
// {block_id, score} pairs, plus direct checks of level, pending and counters.

module tb_guardian_alert_collector;

   localparam int N = 4;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [N-1:0]  alert_valid_in;
   logic [16*N-1:0] anomaly_score_in;
   logic [16*N-1:0] block_id_in;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_block_id;
   logic [15:0]   out_score;
   logic [3:0]    fifo_level;
   logic [N-1:0]  pending_mask;
   logic [15:0]   coalesce_count;

   typedef struct {
      int          g;
      logic [15:0] score;
      logic [15:0] id;
      logic        en;
      logic        exp_acc;
   } thr_vec_t;

   thr_vec_t    thr_tab [6];
   logic [31:0] exp_q [$];
   logic [31:0] mon_exp;
   logic [3:0]  vm;
   int          tests = 0;
   int          fails = 0;

   guardian_alert_collector #(
      .N_GUARDIANS (N),
      .FIFO_DEPTH  (D),
      .SCORE_THRESH(16'd64)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .alert_valid_in  (alert_valid_in),
      .anomaly_score_in(anomaly_score_in),
      .block_id_in     (block_id_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_block_id    (out_block_id),
      .out_score       (out_score),
      .fifo_level      (fifo_level),
      .pending_mask    (pending_mask),
      .coalesce_count  (coalesce_count)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Scoreboard: every accepted head entry must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_pop: got %0h expected none", {out_block_id, out_score});
         end else begin
            mon_exp = exp_q.pop_front();
            if ({out_block_id, out_score} !== mon_exp) begin
               fails++;
               $display("[TB] FAIL pop_order: got id=%0d score=%0d expected id=%0d score=%0d",
                        out_block_id, out_score, mon_exp[31:16], mon_exp[15:0]);
            end
         end
      end
   end

   function automatic logic [63:0] slot(input int g, input logic [15:0] v);
      logic [63:0] r;
      r = '0;
      r[16*g +: 16] = v;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Holds one alert pattern for exactly one clock edge, then returns to idle.
   task automatic applyStimulus(input logic [3:0] v, input logic [63:0] sc, input logic [63:0] ids,
                                input logic en);
      alert_valid_in   = v;
      anomaly_score_in = sc;
      block_id_in      = ids;
      enable           = en;
      @(posedge clk);
      #1;
      alert_valid_in   = '0;
      enable           = 1'b1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      thr_tab[0] = '{0, 16'd63,     16'd1, 1'b1, 1'b0};
      thr_tab[1] = '{0, 16'd64,     16'd2, 1'b1, 1'b1};
      thr_tab[2] = '{1, 16'd0,      16'd3, 1'b1, 1'b0};
      thr_tab[3] = '{2, 16'd65,     16'd4, 1'b1, 1'b1};
      thr_tab[4] = '{1, 16'd200,    16'd6, 1'b0, 1'b0};
      thr_tab[5] = '{3, 16'hFFFF,   16'd7, 1'b1, 1'b1};

      rst_n            = 1'b0;
      enable           = 1'b1;
      alert_valid_in   = '0;
      anomaly_score_in = '0;
      block_id_in      = '0;
      out_ready        = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_level", 32'(fifo_level), 32'd0);
      checkOutput("rst_pending", 32'(pending_mask), 32'd0);
      checkOutput("rst_coalesce", 32'(coalesce_count), 32'd0);
      checkOutput("rst_block_id", 32'(out_block_id), 32'd0);
      checkOutput("rst_score", 32'(out_score), 32'd0);
      rst_n = 1'b1;
      tick(1);

      // Single alert from guardian 2.
      out_ready = 1'b1;
      exp_q.push_back({16'd5, 16'd150});
      applyStimulus(4'b0100, slot(2, 16'd150), slot(2, 16'd5), 1'b1);
      checkOutput("single_pending", 32'(pending_mask), 32'h4);
      checkOutput("single_early_valid", 32'(out_valid), 32'd0);
      tick(1);
      checkOutput("single_valid", 32'(out_valid), 32'd1);
      checkOutput("single_id", 32'(out_block_id), 32'd5);
      checkOutput("single_score", 32'(out_score), 32'd150);
      checkOutput("single_level", 32'(fifo_level), 32'd1);
      tick(1);
      checkOutput("single_drained_valid", 32'(out_valid), 32'd0);
      checkOutput("single_drained_level", 32'(fifo_level), 32'd0);

      // Threshold and enable vectors; the last accepted one is guardian 3.
      for (int i = 0; i < 6; i++) begin
         vm = '0;
         vm[thr_tab[i].g] = 1'b1;
         if (thr_tab[i].exp_acc) begin
            exp_q.push_back({thr_tab[i].id, thr_tab[i].score});
         end
         applyStimulus(vm, slot(thr_tab[i].g, thr_tab[i].score), slot(thr_tab[i].g, thr_tab[i].id),
                       thr_tab[i].en);
         checkOutput("thr_pending", 32'(pending_mask), thr_tab[i].exp_acc ? 32'(vm) : 32'd0);
         tick(3);
         checkOutput("thr_level", 32'(fifo_level), 32'd0);
      end

      // Simultaneous burst from guardians 0, 1, 3 with search starting at 0.
      exp_q.push_back({16'd10, 16'd100});
      exp_q.push_back({16'd11, 16'd100});
      exp_q.push_back({16'd13, 16'd100});
      applyStimulus(4'b1011, slot(0, 16'd100) | slot(1, 16'd100) | slot(3, 16'd100),
                    slot(0, 16'd10) | slot(1, 16'd11) | slot(3, 16'd13), 1'b1);
      checkOutput("rr_pending", 32'(pending_mask), 32'hB);
      tick(6);
      checkOutput("rr_level", 32'(fifo_level), 32'd0);
      exp_q.push_back({16'd10, 16'd100});
      exp_q.push_back({16'd13, 16'd100});
      applyStimulus(4'b1001, slot(0, 16'd100) | slot(3, 16'd100),
                    slot(0, 16'd10) | slot(3, 16'd13), 1'b1);
      tick(5);
      checkOutput("rr2_level", 32'(fifo_level), 32'd0);
      checkOutput("rr2_pending", 32'(pending_mask), 32'd0);

      // Fill the FIFO with back-to-back alerts, then coalesce on guardian 1.
      out_ready = 1'b0;
      for (int j = 0; j < 8; j++) begin
         exp_q.push_back({16'(100 + j), 16'd100});
         applyStimulus(4'b0001, slot(0, 16'd100), slot(0, 16'(100 + j)), 1'b1);
      end
      tick(1);
      checkOutput("fill_level", 32'(fifo_level), 32'd8);
      checkOutput("fill_pending", 32'(pending_mask), 32'd0);
      checkOutput("fill_head", 32'(out_block_id), 32'd100);
      applyStimulus(4'b0010, slot(1, 16'd100), slot(1, 16'd21), 1'b1);
      applyStimulus(4'b0010, slot(1, 16'd300), slot(1, 16'd22), 1'b1);
      applyStimulus(4'b0010, slot(1, 16'd200), slot(1, 16'd23), 1'b1);
      exp_q.push_back({16'd23, 16'd300});
      checkOutput("coal_pending", 32'(pending_mask), 32'h2);
      checkOutput("coal_count", 32'(coalesce_count), 32'd2);
      checkOutput("coal_level", 32'(fifo_level), 32'd8);
      checkOutput("coal_head_id", 32'(out_block_id), 32'd100);
      checkOutput("coal_head_score", 32'(out_score), 32'd100);
      out_ready = 1'b1;
      tick(12);
      checkOutput("coal_drain_level", 32'(fifo_level), 32'd0);
      checkOutput("coal_drain_pending", 32'(pending_mask), 32'd0);
      checkOutput("coal_count_kept", 32'(coalesce_count), 32'd2);

      // Backpressure: ten alerts rotating over the guardians while the consumer stalls.
      out_ready = 1'b0;
      for (int j = 0; j < 10; j++) begin
         vm = '0;
         vm[j % 4] = 1'b1;
         exp_q.push_back({16'(30 + j), 16'd200});
         applyStimulus(vm, slot(j % 4, 16'd200), slot(j % 4, 16'(30 + j)), 1'b1);
      end
      checkOutput("bp_level", 32'(fifo_level), 32'd8);
      checkOutput("bp_pending", 32'(pending_mask), 32'h3);
      checkOutput("bp_head", 32'(out_block_id), 32'd30);
      tick(3);
      checkOutput("bp_hold_id", 32'(out_block_id), 32'd30);
      checkOutput("bp_hold_score", 32'(out_score), 32'd200);
      checkOutput("bp_hold_level", 32'(fifo_level), 32'd8);
      out_ready = 1'b1;
      tick(14);
      checkOutput("bp_drain_level", 32'(fifo_level), 32'd0);
      checkOutput("bp_drain_pending", 32'(pending_mask), 32'd0);
      checkOutput("bp_coalesce", 32'(coalesce_count), 32'd2);

      // Reset mid-operation with five queued entries and guardians 1, 2 pending.
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         applyStimulus(4'b0001, slot(0, 16'd100), slot(0, 16'(50 + j)), 1'b1);
      end
      applyStimulus(4'b0110, slot(1, 16'd100) | slot(2, 16'd100),
                    slot(1, 16'd61) | slot(2, 16'd62), 1'b1);
      checkOutput("pre_rst_level", 32'(fifo_level), 32'd5);
      checkOutput("pre_rst_pending", 32'(pending_mask), 32'h6);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
      checkOutput("mid_rst_pending", 32'(pending_mask), 32'd0);
      checkOutput("mid_rst_coalesce", 32'(coalesce_count), 32'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      out_ready = 1'b1;
      exp_q.push_back({16'd5, 16'd150});
      applyStimulus(4'b0100, slot(2, 16'd150), slot(2, 16'd5), 1'b1);
      checkOutput("post_rst_pending", 32'(pending_mask), 32'h4);
      tick(1);
      checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
      checkOutput("post_rst_id", 32'(out_block_id), 32'd5);
      checkOutput("post_rst_score", 32'(out_score), 32'd150);
      tick(1);
      checkOutput("post_rst_level", 32'(fifo_level), 32'd0);

      tick(2);
      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
